// File: rtl/sort_pkg.sv
// Shared definitions for the four-element sort sequencer: FSM states and
// the compare-exchange schedule that forms a 4-input sorting network.
package sort_pkg;

    localparam int NUM_STEPS = 5;
    localparam int STEP_W    = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef struct packed {
        logic [1:0] first;
        logic [1:0] second;
    } pair_t;

    // One nibble per step, step 0 in the low nibble: {first, second}.
    localparam logic [NUM_STEPS*4-1:0] SCHEDULE = {
        4'b01_10,   // step 4: (r1,r2)
        4'b01_11,   // step 3: (r1,r3)
        4'b00_10,   // step 2: (r0,r2)
        4'b10_11,   // step 1: (r2,r3)
        4'b00_01    // step 0: (r0,r1)
    };

    function automatic pair_t sched_pair(input logic [STEP_W-1:0] step);
        logic [4:0] base;
        base = {step, 2'b00};
        return pair_t'(SCHEDULE[base +: 4]);
    endfunction

endpackage

// File: rtl/sort_cmp_exchange.sv
// Combinational compare-exchange: hi_first takes the larger operand when
// order=0 and the smaller when order=1; equal operands pass through unswapped.
module sort_cmp_exchange #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] p,
    input  logic [WIDTH-1:0] q,
    input  logic             order,
    output logic [WIDTH-1:0] hi_first,
    output logic [WIDTH-1:0] lo_second
);

    logic w_swap;

    assign w_swap    = order ? (q < p) : (p < q);
    assign hi_first  = w_swap ? q : p;
    assign lo_second = w_swap ? p : q;

endmodule

// File: rtl/sort_sequencer.sv
// Four-element sorter that time-shares one compare-exchange unit over a
// five-step network, with valid/ready handshakes on input and output.
module sort_sequencer
    import sort_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    input  logic [WIDTH-1:0] d,
    input  logic             order,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] x,
    output logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] z,
    output logic [WIDTH-1:0] w,
    output logic             busy,
    output logic [CNT_W-1:0] sort_count,
    output logic [1:0]       o_dbg_state
);

    // Handshakes: a transfer happens on a rising edge where valid and ready
    // are both high; ready never depends on valid, and valid/data stay put
    // until the transfer occurs.

    state_t             r_state;
    state_t             w_next;
    logic [WIDTH-1:0]   r_elem [4];
    logic [STEP_W-1:0]  r_step;
    logic               r_order;
    logic [CNT_W-1:0]   r_count;

    pair_t              w_pair;
    logic [WIDTH-1:0]   w_p;
    logic [WIDTH-1:0]   w_q;
    logic [WIDTH-1:0]   w_hi;
    logic [WIDTH-1:0]   w_lo;
    logic               w_accept;
    logic               w_deliver;
    logic               w_last;

    assign w_pair    = sched_pair(r_step);
    assign w_p       = r_elem[w_pair.first];
    assign w_q       = r_elem[w_pair.second];
    assign w_accept  = in_valid && in_ready;
    assign w_deliver = out_valid && out_ready;
    assign w_last    = (r_step == STEP_W'(NUM_STEPS - 1));

    sort_cmp_exchange #(
        .WIDTH(WIDTH)
    ) u_cmp (
        .p        (w_p),
        .q        (w_q),
        .order    (r_order),
        .hi_first (w_hi),
        .lo_second(w_lo)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_next = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (w_last) begin
                    w_next = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_next = IDLE;
                end
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                r_elem[i] <= '0;
            end
            r_step  <= '0;
            r_order <= 1'b0;
            r_count <= '0;
        end else begin
            if (w_accept) begin
                r_elem[0] <= a;
                r_elem[1] <= b;
                r_elem[2] <= c;
                r_elem[3] <= d;
                r_order   <= order;
                r_step    <= '0;
            end else if (r_state == RUN) begin
                r_elem[w_pair.first]  <= w_hi;
                r_elem[w_pair.second] <= w_lo;
                r_step                <= r_step + 1'b1;
            end
            if (w_deliver) begin
                r_count <= r_count + 1'b1;
            end
        end
    end

    assign x           = r_elem[0];
    assign y           = r_elem[1];
    assign z           = r_elem[2];
    assign w           = r_elem[3];
    assign sort_count  = r_count;
    assign o_dbg_state = r_state;

endmodule
